// File: rtl/qspi_prefetch_pkg.sv
// Shared definitions for the QSPI instruction prefetch buffer.
//   state_e        : prefetch FSM states
//   DATA_BITS      : flash / instruction halfword width
//   swap_halfword  : converts a big-endian flash word into a little-endian halfword
package qspi_prefetch_pkg;

    localparam int unsigned DATA_BITS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STOP   = 2'd1,
        START  = 2'd2,
        STREAM = 2'd3
    } state_e;

    // Flash puts the lower-address byte in [15:8]; the CPU expects it in [7:0].
    function automatic logic [DATA_BITS-1:0] swap_halfword(input logic [DATA_BITS-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO for the prefetch buffer.
//   clk, rstn   : clock, synchronous active-low reset
//   flush       : empties the FIFO; overrides every other request
//   push/push_data : enqueue one entry (ignored when full)
//   pop         : dequeue one entry (ignored when empty or when dropping)
//   drop/drop_cnt  : discard drop_cnt entries from the head in one cycle
//   head_data   : head entry, zero when empty
//   count/full/empty : occupancy
module prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned PTR_BITS = $clog2(DEPTH),
    localparam int unsigned CNT_BITS = PTR_BITS + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    input  logic                drop,
    input  logic [PTR_BITS-1:0] drop_cnt,
    output logic [WIDTH-1:0]    head_data,
    output logic [CNT_BITS-1:0] count,
    output logic                full,
    output logic                empty
);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                push_ok, pop_ok;

    assign full      = (count_q == CNT_BITS'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty && !drop;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (drop) begin
                rd_ptr_d = rd_ptr_q + drop_cnt;
            end else if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_BITS'(push_ok)
                    - (drop ? CNT_BITS'(drop_cnt) : CNT_BITS'(pop_ok));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_data is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/qspi_prefetch_buffer.sv
// Instruction prefetch stage between the CPU fetch port and the QSPI flash controller.
//   clk, rstn          : clock, synchronous active-low reset
//   redirect, redirect_addr : CPU fetch redirect (bit 0 ignored)
//   instr_valid/data/addr, instr_ready : CPU halfword port, little-endian data
//   flash_addr, flash_start_read, flash_stop_read : stream control to the controller
//   flash_stall_read   : holds controller data while the FIFO is full
//   flash_data, flash_data_ready, flash_busy : controller read stream and status
module qspi_prefetch_buffer
    import qspi_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 24,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 redirect,
    input  logic [ADDR_BITS-1:0] redirect_addr,
    output logic                 instr_valid,
    output logic [DATA_BITS-1:0] instr_data,
    output logic [ADDR_BITS-1:0] instr_addr,
    input  logic                 instr_ready,
    output logic [ADDR_BITS-1:0] flash_addr,
    output logic                 flash_start_read,
    output logic                 flash_stop_read,
    output logic                 flash_stall_read,
    input  logic [DATA_BITS-1:0] flash_data,
    input  logic                 flash_data_ready,
    input  logic                 flash_busy
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;
    localparam logic [ADDR_BITS-1:0] HALF_STEP = ADDR_BITS'(2);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 dup_q, dup_d;
    logic                 stop_q, stop_d;

    logic [ADDR_BITS-1:0] target, offset;
    logic                 hit, miss, acc, pop;
    logic [PTR_BITS-1:0]  drop_cnt;
    logic [DATA_BITS-1:0] fifo_head;
    logic [CNT_BITS-1:0]  fifo_count;
    logic                 fifo_full, fifo_empty;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (miss),
        .push      (acc),
        .push_data (swap_halfword(flash_data)),
        .pop       (pop),
        .drop      (hit),
        .drop_cnt  (drop_cnt),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        target   = redirect_addr & ~ADDR_BITS'(1);
        // Modular distance from the head; a hit lies within the stored halfwords only.
        offset   = target - rd_addr_q;
        hit      = redirect && (state_q == STREAM) && !fifo_empty
                && (offset < ADDR_BITS'({fifo_count, 1'b0}));
        miss     = redirect && !hit;
        drop_cnt = offset[PTR_BITS:1];
        // dup_q masks the repeated data_ready the controller emits after a stall release.
        acc      = (state_q == STREAM) && flash_data_ready && !fifo_full && !dup_q;
        pop      = !fifo_empty && instr_ready && !redirect;
    end

    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        rd_addr_d   = rd_addr_q;
        dup_d       = acc;
        stop_d      = miss;

        case (state_q)
            IDLE:    state_d = IDLE;
            STOP:    state_d = START;
            START:   if (!flash_busy) state_d = STREAM;
            STREAM:  state_d = STREAM;
            default: state_d = IDLE;
        endcase

        if (miss) begin
            state_d     = STOP;
            fetch_ptr_d = target;
        end else if (acc) begin
            fetch_ptr_d = fetch_ptr_q + HALF_STEP;
        end

        if (redirect) begin
            rd_addr_d = target;
        end else if (pop) begin
            rd_addr_d = rd_addr_q + HALF_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            fetch_ptr_q <= '0;
            rd_addr_q   <= '0;
            dup_q       <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            rd_addr_q   <= rd_addr_d;
            dup_q       <= dup_d;
            stop_q      <= stop_d;
        end
    end

    // Start must coincide with the cycle the controller reports idle, so it is
    // decoded from the START state rather than registered.
    assign flash_start_read = (state_q == START) && !flash_busy && !redirect;
    assign flash_stop_read  = stop_q;
    assign flash_addr       = fetch_ptr_q;
    assign flash_stall_read = fifo_full;
    assign instr_valid      = !fifo_empty;
    assign instr_data       = fifo_head;
    assign instr_addr       = rd_addr_q;

endmodule

// File: tb/tb_qspi_prefetch_buffer.sv
// Self-checking bench for qspi_prefetch_buffer with a behavioural flash controller
// and a scoreboard of expected CPU halfwords.
module tb_qspi_prefetch_buffer;

    localparam int unsigned AW    = 24;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          instr_valid;
    logic [15:0]   instr_data;
    logic [AW-1:0] instr_addr;
    logic          instr_ready;
    logic [AW-1:0] flash_addr;
    logic          flash_start_read;
    logic          flash_stop_read;
    logic          flash_stall_read;
    logic [15:0]   flash_data;
    logic          flash_data_ready;
    logic          flash_busy;

    always #5 clk = ~clk;

    qspi_prefetch_buffer #(
        .ADDR_BITS (AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .redirect         (redirect),
        .redirect_addr    (redirect_addr),
        .instr_valid      (instr_valid),
        .instr_data       (instr_data),
        .instr_addr       (instr_addr),
        .instr_ready      (instr_ready),
        .flash_addr       (flash_addr),
        .flash_start_read (flash_start_read),
        .flash_stop_read  (flash_stop_read),
        .flash_stall_read (flash_stall_read),
        .flash_data       (flash_data),
        .flash_data_ready (flash_data_ready),
        .flash_busy       (flash_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flash image: two fixed words at 0x100, a hash of the address elsewhere.
    function automatic logic [7:0] fbyte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
    endfunction

    function automatic logic [15:0] fword(input logic [AW-1:0] a);
        logic [AW-1:0] a1;
        a1 = a + 24'd1;
        if (a == 24'h000100) return 16'h1234;
        if (a == 24'h000102) return 16'hABCD;
        return {fbyte(a), fbyte(a1)};
    endfunction

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } sb_t;

    sb_t sbq[$];

    // Controller model state
    logic          c_active = 1'b0;
    logic          c_hold   = 1'b0;
    logic          c_dup    = 1'b0;
    logic [AW-1:0] c_addr   = '0;
    int            c_lat    = 0;

    // Values seen at the edge the controller reacts to
    logic          s_rstn, s_start, s_stop, s_stall;
    logic [AW-1:0] s_faddr;

    task automatic ctrl_drive();
        if (!s_rstn || s_stop) begin
            c_active         = 1'b0;
            c_hold           = 1'b0;
            c_dup            = 1'b0;
            flash_data_ready = 1'b0;
        end else if (s_start) begin
            c_active         = 1'b1;
            c_addr           = s_faddr;
            c_lat            = 1;
            c_hold           = 1'b0;
            c_dup            = 1'b0;
            flash_data_ready = 1'b0;
        end else if (c_active) begin
            if (flash_data_ready && !c_dup) begin
                if (s_stall) begin
                    c_hold = 1'b1;
                end else begin
                    c_addr = c_addr + 24'd2;
                    if (c_hold) c_dup = 1'b1;     // repeat same word once
                    else        flash_data_ready = 1'b0;
                    c_hold = 1'b0;
                end
            end else if (c_dup) begin
                c_dup            = 1'b0;
                flash_data_ready = 1'b0;
            end else if (c_lat > 0) begin
                c_lat--;
            end else begin
                flash_data_ready = 1'b1;
                flash_data       = fword(c_addr);
            end
        end
    endtask

    // One clock: compare current outputs, update scoreboard for the coming edge,
    // advance, then let the controller react.
    task automatic step();
        logic [AW-1:0] tgt;
        logic [AW-1:0] diff;
        logic          push_ok;
        logic [15:0]   w;
        sb_t           e;
        int            n;

        check("head_valid", instr_valid, sbq.size() != 0);
        if (sbq.size() != 0) begin
            check("head_addr", instr_addr, sbq[0].addr);
            check("head_data", instr_data, sbq[0].data);
        end
        check("stall", flash_stall_read, sbq.size() == DEPTH);

        push_ok = c_active && flash_data_ready && !c_dup && !flash_stall_read
               && !flash_stop_read && rstn;
        s_rstn  = rstn;
        s_start = flash_start_read;
        s_stop  = flash_stop_read;
        s_stall = flash_stall_read;
        s_faddr = flash_addr;

        if (!rstn) begin
            sbq.delete();
            push_ok = 1'b0;
        end else if (redirect) begin
            tgt  = redirect_addr & 24'hFFFFFE;
            diff = (sbq.size() != 0) ? tgt - sbq[0].addr : 24'd0;
            if (sbq.size() != 0 && int'(diff) < 2 * sbq.size()) begin
                n = int'(diff) / 2;
                for (int i = 0; i < n; i++) void'(sbq.pop_front());
            end else begin
                sbq.delete();
                push_ok = 1'b0;
            end
        end else if (instr_ready && sbq.size() != 0) begin
            void'(sbq.pop_front());
        end

        if (push_ok) begin
            w      = fword(c_addr);
            e.addr = c_addr;
            e.data = {w[7:0], w[15:8]};
            sbq.push_back(e);
        end

        @(posedge clk);
        @(negedge clk);
        ctrl_drive();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_data"},  instr_data, 16'h0);
        check({tag, "_iaddr"}, instr_addr, 24'h0);
        check({tag, "_start"}, flash_start_read, 1'b0);
        check({tag, "_stop"},  flash_stop_read, 1'b0);
        check({tag, "_faddr"}, flash_addr, 24'h0);
        check({tag, "_stall"}, flash_stall_read, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30 && !instr_valid; i++) step();
        check(tag, instr_valid, 1'b1);
    endtask

    task automatic wait_full(input string tag);
        for (int i = 0; i < 40 && !flash_stall_read; i++) step();
        check(tag, flash_stall_read, 1'b1);
    endtask

    // Miss redirect with the expected stop/start sequence.
    task automatic miss_redirect(input string tag, input logic [AW-1:0] a);
        redirect      = 1'b1;
        redirect_addr = a;
        step();
        redirect = 1'b0;
        check({tag, "_stop"},   flash_stop_read, 1'b1);
        check({tag, "_vlow"},   instr_valid, 1'b0);
        check({tag, "_nostart"}, flash_start_read, 1'b0);
        step();
        check({tag, "_start"}, flash_start_read, 1'b1);
        check({tag, "_faddr"}, flash_addr, a & 24'hFFFFFE);
        check({tag, "_stop2"}, flash_stop_read, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn             = 1'b0;
        redirect         = 1'b0;
        redirect_addr    = '0;
        instr_ready      = 1'b0;
        flash_data       = '0;
        flash_data_ready = 1'b0;
        flash_busy       = 1'b0;
        s_rstn = 1'b0; s_start = 1'b0; s_stop = 1'b0; s_stall = 1'b0; s_faddr = '0;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;

        // No flash activity before the first redirect
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_nostart", flash_start_read, 1'b0);
            check("idle_nostop",  flash_stop_read, 1'b0);
        end

        // Miss redirect to 0x100, buffer until full
        miss_redirect("miss1", 24'h000100);
        wait_valid("miss1_first_valid");
        check("miss1_first_data", instr_data, 16'h3412);
        check("miss1_first_addr", instr_addr, 24'h000100);
        wait_full("miss1_full");

        // Hit redirect to 0x104 while holding 0x100..0x106
        redirect      = 1'b1;
        redirect_addr = 24'h000104;
        step();
        redirect = 1'b0;
        check("hit_nostop",  flash_stop_read, 1'b0);
        check("hit_nostart", flash_start_read, 1'b0);
        check("hit_addr",    instr_addr, 24'h000104);
        check("hit_notfull", flash_stall_read, 1'b0);
        step();
        check("hit_nostop2", flash_stop_read, 1'b0);

        // Stall handshake: controller holds while full, one pop admits one word
        wait_full("stall_full");
        for (int i = 0; i < 3; i++) step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("stall_refill", flash_stall_read, 1'b1);

        // Continuous draining exercises the post-stall duplicate
        instr_ready = 1'b1;
        for (int i = 0; i < 24; i++) step();

        // Miss mid-stream
        miss_redirect("miss2", 24'h000200);
        for (int i = 0; i < 16; i++) step();

        // Wrap-around
        instr_ready = 1'b0;
        miss_redirect("wrap", 24'hFFFFFE);
        wait_full("wrap_full");
        check("wrap_first_addr", instr_addr, 24'hFFFFFE);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("wrap_second_addr", instr_addr, 24'h000000);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Reset mid-stream
        rstn = 1'b0;
        step();
        check_reset_outputs("midrst");
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("midrst_nostart", flash_start_read, 1'b0);
        end

        // Recovery with a busy controller delaying the start
        flash_busy    = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 24'h000041;
        step();
        redirect = 1'b0;
        check("busy_stop", flash_stop_read, 1'b1);
        step();
        check("busy_hold", flash_start_read, 1'b0);
        step();
        check("busy_hold2", flash_start_read, 1'b0);
        flash_busy = 1'b0;
        #1;
        check("busy_start", flash_start_read, 1'b1);
        check("busy_faddr", flash_addr, 24'h000040);
        for (int i = 0; i < 20; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qspi_prefetch_buffer.md
# qspi_prefetch_buffer

Instruction prefetch stage between the CPU fetch port and the QSPI read-only flash controller (16-bit data word, 24-bit address). Starts a continuous flash read stream on every CPU redirect and buffers the returned halfwords in a small FIFO. Throttles the controller through its stall handshake and serves halfwords to the CPU in little-endian order, each tagged with its address. Redirects that land inside the buffered window are absorbed without restarting the flash.

## Interface
- ADDR_BITS, 24, flash byte address width
- DEPTH, 4, FIFO entries of 16 bits; power of two, ≥2
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- redirect  in  1  CPU requests fetch from redirect_addr
- redirect_addr  in  ADDR_BITS  target address; bit 0 ignored
- instr_valid  out  1  head halfword available
- instr_data  out  16  head halfword, little-endian
- instr_addr  out  ADDR_BITS  byte address of head halfword
- instr_ready  in  1  CPU pops head when instr_valid
- flash_addr  out  ADDR_BITS  read start address
- flash_start_read  out  1  one-cycle start pulse
- flash_stop_read  out  1  one-cycle cancel pulse
- flash_stall_read  out  1  hold controller data
- flash_data  in  16  big-endian word: lower-address byte in [15:8]
- flash_data_ready  in  1  word valid
- flash_busy  in  1  controller not idle

## Operation
- FSM states: IDLE, STOP, START, STREAM. Reset → IDLE.
- IDLE: wait for redirect. No flash activity after reset until the first redirect.
- Redirect hit condition: FIFO count > 0 and (target − instr_addr) mod 2^ADDR_BITS < 2·count.
  - On a hit: drop (target − instr_addr)/2 entries in one cycle and stay in STREAM.
  - Only stored entries count toward a hit. A word accepted in the same cycle is still enqueued.
- Redirect miss, or any redirect in IDLE/STOP/START:
  - Flush the FIFO and latch target into the fetch pointer.
  - Go to STOP.
- STOP: flash_stop_read=1 for one cycle, then go to START.
- START: when !flash_busy, assert flash_start_read=1 with flash_addr = fetch pointer, then go to STREAM.
- STREAM word acceptance:
  - acc = flash_data_ready & !flash_stall_read & !dup, with dup <= acc registered.
  - dup suppresses the repeated data_ready the controller emits in the cycle after a stall release.
- On acc: enqueue {flash_data[7:0], flash_data[15:8]} and advance the write-side address by 2.
- flash_stall_read = FIFO full (combinational).
- Pop on instr_valid & instr_ready. instr_addr += 2.
- All address arithmetic is mod 2^ADDR_BITS; 0xFFFFFE is followed by 0x000000.
- Simultaneous events:
  - Redirect and pop in the same cycle: the redirect wins and the pop is ignored.
  - Accept and pop in the same cycle: count is unchanged.

## Timing
- Reset values:
  - instr_valid=0, instr_addr=0, instr_data=0.
  - flash_start_read=0, flash_stop_read=0, flash_addr=0, flash_stall_read=0.
  - FIFO empty, dup=0.
- Miss redirect sampled at edge R:
  - stop_read high in cycle R+1.
  - start_read high in R+2 (if !flash_busy).
  - instr_valid low from R+1.
- Hit redirect at edge R: new head visible in R+1; no flash pulses.
- Accepted word is visible on instr_* the next cycle when the FIFO was empty.
- rstn low mid-operation:
  - Every output returns to its reset value the next cycle.
  - Any stream in progress is discarded. The controller shares rstn.

## Structure
- Package qspi_prefetch_pkg holds the state enum (IDLE, STOP, START, STREAM), DATA_BITS=16 and the halfword byte-swap function.
- Sub-module prefetch_fifo: synchronous FIFO, DEPTH×16, push/pop/flush, multi-entry drop port, count output.
- The top level holds the FSM, the address pointers and the dup register.

## Test plan
- Miss redirect:
  - Stimulus: redirect to 0x000100; flash returns 0x1234 then 0xABCD.
  - Response: stop_read in R+1, start_read with flash_addr=0x000100 in R+2. The CPU sees 0x3412 @0x000100, then 0xCDAB @0x000102.
- Stall handshake:
  - Stimulus: no pops until 4 words are buffered; stall_read goes high and the controller holds data_ready for 3 cycles. Then pop once.
  - Response: exactly one additional word is enqueued (count stays 4); no duplicate word appears.
- Hit redirect:
  - Stimulus: FIFO holds 0x100–0x106; redirect to 0x104.
  - Response: no stop_read. Next cycle instr_addr=0x104 with count 2.
- Miss mid-stream:
  - Stimulus: redirect to 0x200 while streaming.
  - Response: instr_valid=0 in R+1, stop_read in R+1, start_read with 0x200 in R+2.
- Wrap-around:
  - Stimulus: redirect to 0xFFFFFE.
  - Response: second halfword tagged 0x000000.
- Reset mid-stream:
  - Stimulus: rstn low for 1 cycle while streaming.
  - Response: all outputs zero next cycle; no further start_read until a new redirect.
